// File: rtl/reg_wr_cmd_decoder_if.sv
// Byte-stream input and register-write output bundle of the write-command decoder.
interface reg_wr_cmd_decoder_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [15:0]      data_out;
  logic [15:0]      sel;
  logic [3:0]       sel_dir;
  logic             frame_err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] wr_count;

  modport master (
    output rx_data, rx_valid,
    input  data_out, sel, sel_dir, frame_err, err_code, wr_count
  );

  modport slave (
    input  rx_data, rx_valid,
    output data_out, sel, sel_dir, frame_err, err_code, wr_count
  );
endinterface

// File: rtl/reg_wr_cmd_decoder.sv
// Assembles HEADER/ADDR/DATA[/CSUM] frames from a byte stream and issues one-hot register writes.
// Define REG_WR_CKSUM_EN for 4-byte frames with an XOR checksum; default is 3-byte frames.
module reg_wr_cmd_decoder #(
  parameter logic [7:0] HEADER         = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter int         CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_wr_cmd_decoder_if.slave  bus
);

  localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_CKSUM   = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_CSUM = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q;
  logic             timeout;
  logic             commit_d, drop_d;
  logic [1:0]       err_d;
  logic [6:0]       wr_addr;
  logic [7:0]       wr_data;

  // Captured frame fields: {CLR, bank[1:0], index[3:0]}; ADDR[6] is not kept.
  logic [6:0]       addr_p0;
`ifdef REG_WR_CKSUM_EN
  logic [7:0]       data_p0;
  logic [7:0]       cks_p0;
`endif

  logic [15:0]      data_out_q;
  logic [15:0]      sel_q;
  logic [3:0]       sel_dir_q;
  logic             frame_err_q;
  logic [1:0]       err_code_q;
  logic [CNT_W-1:0] wr_count_q;

  function automatic logic range_ok(input logic [6:0] a);
    return (a[5:4] == 2'd0) || ((a[5:4] == 2'd1) && (a[3:2] == 2'd0));
  endfunction

  function automatic logic [15:0] sel_decode(input logic [6:0] a);
    if (a[5:4] == 2'd0) return 16'h0001 << a[3:0];
    return 16'h0000;
  endfunction

  function automatic logic [3:0] dir_decode(input logic [6:0] a);
    if ((a[5:4] == 2'd1) && (a[3:2] == 2'd0)) return 4'h1 << a[1:0];
    return 4'h0;
  endfunction

  always_comb begin
    state_d  = state_q;
    commit_d = 1'b0;
    drop_d   = 1'b0;
    err_d    = 2'd0;
    timeout  = (timer_q == TMR_LAST);
    wr_addr  = addr_p0;
`ifdef REG_WR_CKSUM_EN
    wr_data  = data_p0;
`else
    wr_data  = bus.rx_data;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid && (bus.rx_data == HEADER)) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (bus.rx_valid) begin
          state_d = S_DATA;
        end else if (timeout) begin
          state_d = S_IDLE;
          drop_d  = 1'b1;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_DATA: begin
        if (bus.rx_valid) begin
`ifdef REG_WR_CKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_IDLE;
          if (range_ok(addr_p0)) begin
            commit_d = 1'b1;
          end else begin
            drop_d = 1'b1;
            err_d  = ERR_RANGE;
          end
`endif
        end else if (timeout) begin
          state_d = S_IDLE;
          drop_d  = 1'b1;
          err_d   = ERR_TIMEOUT;
        end
      end
`ifdef REG_WR_CKSUM_EN
      S_CSUM: begin
        if (bus.rx_valid) begin
          state_d = S_IDLE;
          if (bus.rx_data != cks_p0) begin
            drop_d = 1'b1;
            err_d  = ERR_CKSUM;
          end else if (range_ok(addr_p0)) begin
            commit_d = 1'b1;
          end else begin
            drop_d = 1'b1;
            err_d  = ERR_RANGE;
          end
        end else if (timeout) begin
          state_d = S_IDLE;
          drop_d  = 1'b1;
          err_d   = ERR_TIMEOUT;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Control and registered outputs: strobes and error pulses land one cycle after the last byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      data_out_q  <= 16'h0000;
      sel_q       <= 16'h0000;
      sel_dir_q   <= 4'h0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
      wr_count_q  <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) || (state_d == S_IDLE) || bus.rx_valid) timer_q <= '0;
      else                                                            timer_q <= timer_q + 1'b1;
      sel_q       <= commit_d ? sel_decode(wr_addr) : 16'h0000;
      sel_dir_q   <= commit_d ? dir_decode(wr_addr) : 4'h0;
      frame_err_q <= drop_d;
      err_code_q  <= drop_d ? err_d : 2'd0;
      if (commit_d) begin
        data_out_q <= {wr_addr[6], 7'b0, wr_data};
        wr_count_q <= wr_count_q + 1'b1;
      end
    end
  end

  // Frame field capture; only read while the FSM is past the state that loaded it.
  always_ff @(posedge clk) begin
    if (bus.rx_valid && (state_q == S_ADDR)) begin
      addr_p0 <= {bus.rx_data[7], bus.rx_data[5:0]};
`ifdef REG_WR_CKSUM_EN
      cks_p0  <= HEADER ^ bus.rx_data;
`endif
    end
`ifdef REG_WR_CKSUM_EN
    if (bus.rx_valid && (state_q == S_DATA)) begin
      data_p0 <= bus.rx_data;
      cks_p0  <= cks_p0 ^ bus.rx_data;
    end
`endif
  end

  assign bus.data_out  = data_out_q;
  assign bus.sel       = sel_q;
  assign bus.sel_dir   = sel_dir_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code  = err_code_q;
  assign bus.wr_count  = wr_count_q;

endmodule

// File: tb/tb_reg_wr_cmd_decoder.sv
// Directed scoreboard bench for reg_wr_cmd_decoder; follows REG_WR_CKSUM_EN for frame length.
module tb_reg_wr_cmd_decoder;
  localparam logic [7:0] HDR = 8'hA5;
  localparam int         TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  reg_wr_cmd_decoder_if #(.CNT_W(16)) bus();

  reg_wr_cmd_decoder #(.HEADER(HDR), .TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    bit         is_err;
    logic [1:0] code;
    logic [15:0] dout;
    logic [15:0] sel;
    logic [3:0]  sdir;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_assert   = 0;
  int          n_fail     = 0;
  int          cyc        = 0;
  int          exp_cnt    = 0;
  logic [15:0] model_dout = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every strobe or error pulse must match the oldest expected event, on its due cycle.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (bus.frame_err || (|bus.sel) || (|bus.sel_dir)) begin
      if (q.size() == 0) begin
        check("spurious_evt", 32'({bus.frame_err, bus.sel_dir, bus.sel}), 32'd0);
      end else begin
        mon_e = q.pop_front();
        check("evt_cycle", cyc, mon_e.due);
        check("frame_err", 32'(bus.frame_err), 32'(mon_e.is_err));
        check("err_code", 32'(bus.err_code), 32'(mon_e.code));
        check("data_out", 32'(bus.data_out), 32'(mon_e.dout));
        check("sel", 32'(bus.sel), 32'(mon_e.sel));
        check("sel_dir", 32'(bus.sel_dir), 32'(mon_e.sdir));
        if (!mon_e.is_err) exp_cnt++;
        check("wr_count", 32'(bus.wr_count), exp_cnt);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends DATA (and CSUM) after HEADER/ADDR were already sent, queueing the expected outcome.
  task automatic frame_tail(input logic [7:0] a, input logic [7:0] d, input bit bad);
    exp_t e;
    e.due = 0; e.is_err = 1'b0; e.code = 2'd0; e.sel = 16'h0000; e.sdir = 4'h0;
    if (bad) begin
      e.is_err = 1'b1; e.code = 2'd1;
    end else if (a[5:4] == 2'd0) begin
      e.sel = 16'h0001 << a[3:0];
    end else if ((a[5:4] == 2'd1) && (a[3:0] < 4'd4)) begin
      e.sdir = 4'h1 << a[1:0];
    end else begin
      e.is_err = 1'b1; e.code = 2'd2;
    end
    if (!e.is_err) model_dout = {a[7], 7'b0, d};
    e.dout = model_dout;
`ifdef REG_WR_CKSUM_EN
    send_byte(d);
    e.due = cyc + 1;
    q.push_back(e);
    send_byte(HDR ^ a ^ d ^ {7'b0, bad});
`else
    e.due = cyc + 1;
    q.push_back(e);
    send_byte(d);
`endif
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] d, input bit bad);
    send_byte(HDR);
    send_byte(a);
    frame_tail(a, d, bad);
  endtask

  initial begin
    exp_t e;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    idle(3);
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_sel_dir", 32'(bus.sel_dir), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_err_code", 32'(bus.err_code), 32'd0);
    check("rst_wr_count", 32'(bus.wr_count), 32'd0);
    rst = 1'b0;
    idle(2);

    frame(8'h03, 8'h5C, 1'b0);
    frame(8'h12, 8'h0F, 1'b0);
    frame(8'h85, 8'h00, 1'b0);
`ifdef REG_WR_CKSUM_EN
    frame(8'h03, 8'h5C, 1'b1);
`endif
    idle(2);
    frame(8'h14, 8'h33, 1'b0);
    frame(8'h3A, 8'h11, 1'b0);
    frame(8'h25, 8'h77, 1'b0);
    frame(8'h1F, 8'h01, 1'b0);
    frame(8'h4F, 8'hAA, 1'b0);
    frame(8'h00, HDR, 1'b0);
    idle(2);

    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    frame(8'h03, 8'h5C, 1'b0);
    frame(8'h12, 8'h0F, 1'b0);
    idle(3);

    // Byte arriving on the last cycle before the timeout is accepted.
    send_byte(HDR);
    send_byte(8'h03);
    idle(TMO - 1);
    frame_tail(8'h03, 8'h66, 1'b0);
    idle(2);

    send_byte(HDR);
    send_byte(8'h03);
    e.due = cyc + TMO; e.is_err = 1'b1; e.code = 2'd3;
    e.dout = model_dout; e.sel = 16'h0000; e.sdir = 4'h0;
    q.push_back(e);
    idle(TMO + 4);
    frame(8'h0A, 8'h42, 1'b0);
    idle(2);

    send_byte(HDR);
    send_byte(8'h03);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt    = 0;
    model_dout = 16'h0000;
    check("midrst_data_out", 32'(bus.data_out), 32'd0);
    check("midrst_sel", 32'(bus.sel), 32'd0);
    check("midrst_frame_err", 32'(bus.frame_err), 32'd0);
    check("midrst_wr_count", 32'(bus.wr_count), 32'd0);
    send_byte(8'h5C);
    idle(TMO + 4);
    frame(8'h03, 8'h5C, 1'b0);
    idle(5);

    check("queue_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
